// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default rates and bit-period math.
// Optional parity support is selected with the UART_RX_PARITY_EN macro.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 10_000_000;
  localparam int unsigned DEFAULT_BAUDRATE = 115_200;
  localparam int unsigned CNT_W            = 16;
  localparam int unsigned STATE_W          = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  // Clock cycles per serial bit, integer division.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baudrate);
    return clk_freq / baudrate;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling; 8E1 framing when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUDRATE = DEFAULT_BAUDRATE,
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_rx,
  output logic [7:0] data_byte,
  output logic       data_valid,
  output logic       frame_error,
  output logic       parity_error
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUDRATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic w_rx_s;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (input_rx),
    .o_q (w_rx_s)
  );

  uart_state_e      r_state,     w_state;
  logic [CNT_W-1:0] r_clk_cnt,   w_clk_cnt;
  logic [2:0]       r_bit_idx,   w_bit_idx;
  logic [7:0]       r_shift,     w_shift;
  logic [7:0]       r_data_byte, w_data_byte;
  logic             r_data_valid,  w_data_valid;
  logic             r_frame_error, w_frame_error;
`ifdef UART_RX_PARITY_EN
  logic             r_par,          w_par;
  logic             r_parity_error, w_parity_error;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_data_byte   <= 8'h00;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par          <= 1'b0;
      r_parity_error <= 1'b0;
`endif
    end else begin
      r_state       <= w_state;
      r_clk_cnt     <= w_clk_cnt;
      r_bit_idx     <= w_bit_idx;
      r_shift       <= w_shift;
      r_data_byte   <= w_data_byte;
      r_data_valid  <= w_data_valid;
      r_frame_error <= w_frame_error;
`ifdef UART_RX_PARITY_EN
      r_par          <= w_par;
      r_parity_error <= w_parity_error;
`endif
    end
  end

  // Next-state and pulse decode; every sample point is a counter terminal count.
  always_comb begin
    w_state       = r_state;
    w_clk_cnt     = r_clk_cnt;
    w_bit_idx     = r_bit_idx;
    w_shift       = r_shift;
    w_data_byte   = r_data_byte;
    w_data_valid  = 1'b0;
    w_frame_error = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par          = r_par;
    w_parity_error = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_bit_idx = '0;
          w_clk_cnt = '0;
          w_state   = ST_START;
        end
      end
      ST_START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt = '0;
          w_state   = w_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_clk_cnt = r_clk_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_shift[r_bit_idx] = w_rx_s;
          w_clk_cnt          = '0;
          w_bit_idx          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state = ST_PARITY;
`else
            w_state = ST_STOP;
`endif
          end
        end else begin
          w_clk_cnt = r_clk_cnt + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_par     = w_rx_s;
          w_clk_cnt = '0;
          w_state   = ST_STOP;
        end else begin
          w_clk_cnt = r_clk_cnt + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_clk_cnt = '0;
          w_state   = ST_IDLE;
          // A bad stop bit outranks a parity mismatch.
          if (!w_rx_s) begin
            w_frame_error = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if ((^r_shift) != r_par) begin
            w_parity_error = 1'b1;
          end
`endif
          else begin
            w_data_byte  = r_shift;
            w_data_valid = 1'b1;
          end
        end else begin
          w_clk_cnt = r_clk_cnt + CNT_W'(1);
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign data_byte   = r_data_byte;
  assign data_valid  = r_data_valid;
  assign frame_error = r_frame_error;
`ifdef UART_RX_PARITY_EN
  assign parity_error = r_parity_error;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames against a frame-level reference model of uart_rx.
module tb_uart_rx;

  localparam int unsigned CPB = 10_000_000 / 115_200;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int unsigned FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       input_rx;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       frame_error;
  logic       parity_error;

  uart_rx dut (
    .clk          (clk),
    .rst          (rst),
    .input_rx     (input_rx),
    .data_byte    (data_byte),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  int unsigned last_valid_cyc = 0;

  // Observed events
  logic [7:0]  obs_q[$];
  int unsigned obs_fe = 0;
  int unsigned obs_pe = 0;
  int unsigned excl_viol = 0;

  // Expected events from the frame-level model
  logic [7:0]  exp_q[$];
  int unsigned exp_fe = 0;
  int unsigned exp_pe = 0;
  logic [7:0]  last_good = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      obs_q.push_back(data_byte);
      last_valid_cyc = cyc;
    end
    if (frame_error === 1'b1)  obs_fe++;
    if (parity_error === 1'b1) obs_pe++;
    if ((int'(data_valid) + int'(frame_error) + int'(parity_error)) > 1) excl_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    input_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Serialize one frame and record the outcome the line protocol dictates.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit(par_bit);
    drive_bit(stop_bit);
    input_rx = 1'b1;
    if (!stop_bit) exp_fe++;
    else if (PAR_EN && (par_bit != ^b)) exp_pe++;
    else begin
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic idle_bits(input int unsigned n);
    input_rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic checkpoint(input string tag);
    int n;
    check({tag, ".count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, ".byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, ".frame_err"},  32'(obs_fe), 32'(exp_fe));
    check({tag, ".parity_err"}, 32'(obs_pe), 32'(exp_pe));
    check({tag, ".data_byte"},  32'(data_byte), 32'(last_good));
    obs_q.delete();
    exp_q.delete();
    obs_fe = 0; obs_pe = 0; exp_fe = 0; exp_pe = 0;
  endtask

  initial begin
    logic [7:0]  b;
    logic        stop_b;
    logic        par_b;
    int          lat;
    int          nominal;

    rst      = 1'b1;
    input_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.data_byte",    32'(data_byte),    32'h00);
    check("reset.data_valid",   32'(data_valid),   32'h0);
    check("reset.frame_error",  32'(frame_error),  32'h0);
    check("reset.parity_error", 32'(parity_error), 32'h0);
    rst = 1'b0;
    idle_bits(2);

    // Single frame 0x55 and its latency from the start edge.
    send_frame(8'h55, 1'b1, ^8'h55);
    lat     = int'(last_valid_cyc) - int'(start_cyc);
    nominal = (2 * (FRAME_BITS - 1) + 1) * CPB / 2;
    check("f55.latency_ok", 32'((lat >= nominal - 8) && (lat <= nominal + 8)), 32'h1);
    idle_bits(1);
    checkpoint("f55");

    // Short glitch must not start a frame.
    input_rx = 1'b0;
    repeat (20) @(negedge clk);
    input_rx = 1'b1;
    idle_bits(3);
    checkpoint("glitch");

    // Bad stop bit: frame error, data_byte held.
    send_frame(8'hA3, 1'b0, ^8'hA3);
    idle_bits(3);
    checkpoint("stoperr");

    // Back-to-back frames without an idle gap.
    send_frame(8'hA5, 1'b1, ^8'hA5);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    idle_bits(1);
    checkpoint("b2b");

    // Reset in the middle of bit 4 of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    last_good = 8'h00;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle_bits(6);
    checkpoint("rst_mid");
    send_frame(8'h12, 1'b1, ^8'h12);
    idle_bits(1);
    checkpoint("after_rst");

    if (PAR_EN) begin
      send_frame(8'h07, 1'b1, 1'b0);
      idle_bits(1);
      checkpoint("par_bad");
      send_frame(8'h5A, 1'b0, 1'b1);
      idle_bits(3);
      checkpoint("par_and_stop");
    end

    // Randomized frames with occasional stop and parity corruption.
    for (int k = 0; k < 24; k++) begin
      b      = 8'($urandom);
      stop_b = ($urandom_range(0, 5) != 0);
      par_b  = (^b) ^ ($urandom_range(0, 4) == 0);
      send_frame(b, stop_b, par_b);
      if (!stop_b) idle_bits(2);
      else         idle_bits(32'($urandom_range(0, 2)));
      checkpoint("rand");
    end

    check("exclusive_pulses", 32'(excl_viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
